// File: rtl/rr_arbiter8.sv
// -----------------------------------------------------------------------------
// rr_arbiter8
//
// Purpose:
//   Eight-requester round-robin arbiter that shares one downstream resource.
//   The grant is presented both as a binary index (for a 3-to-8 decoder
//   select) and as the equivalent one-hot vector.
//
//   Ownership is bounded:
//   - Once an owner has held the resource for MAX_HOLD cycles, it is forced
//     off as soon as any other requester is waiting.
//   - Every change of owner passes through one dead (GAP) cycle, so the
//     decoded select never overlaps two requesters.
//
// Parameters:
//   MAX_HOLD     maximum consecutive grant cycles while others wait (2..255)
//
// Ports:
//   i_clk        single clock, rising edge
//   i_rst        synchronous active-high reset
//   i_en         1 = new grants may be issued; an existing grant is unaffected
//   i_req[7:0]   level requests, held high while a requester wants/uses the
//                resource
//   o_gnt[7:0]   registered one-hot grant, 8'h00 when idle
//   o_gnt_idx    registered binary owner index; keeps its last value while
//                o_gnt_valid is low
//   o_gnt_valid  1 while o_gnt is non-zero
//   o_preempt    one-cycle pulse during the GAP cycle after a forced release
// -----------------------------------------------------------------------------
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [7:0] i_req,
    output logic [7:0] o_gnt,
    output logic [2:0] o_gnt_idx,
    output logic       o_gnt_valid,
    output logic       o_preempt
);

    // -------------------------------------------------------------------------
    // Controller states
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // The hold counter saturates at this value. An owner that reaches it is
    // released on the first cycle in which someone else is asking.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [7:0] r_gnt;
    logic [2:0] r_gnt_idx;
    logic       r_gnt_valid;
    logic       r_preempt;
    logic [2:0] r_last;
    logic [7:0] r_hold;

    // Next-state values
    logic [1:0] w_state_n;
    logic [7:0] w_gnt_n;
    logic [2:0] w_gnt_idx_n;
    logic       w_gnt_valid_n;
    logic       w_preempt_n;
    logic [2:0] w_last_n;
    logic [7:0] w_hold_n;

    // Arbitration helpers
    logic [2:0] w_win;
    logic       w_can_grant;
    logic       w_owner_req;
    logic       w_others_req;
    logic       w_hold_max;

    // -------------------------------------------------------------------------
    // Round-robin search
    //
    // Scans last+1, last+2, ... last+8 (mod 8) and returns the first index
    // whose request is set. The final probe (k=8) lands on 'last' itself, so
    // the previous owner wins again only when nobody else is requesting.
    // Callers only use the result when at least one request is set; for an
    // empty vector it returns last+1.
    // -------------------------------------------------------------------------
    function automatic logic [2:0] f_rr_pick(input logic [7:0] req,
                                             input logic [2:0] last);
        logic [2:0] idx;
        logic [2:0] pick;
        logic       found;

        pick  = last + 3'd1;
        found = 1'b0;

        for (int k = 1; k <= 8; k++) begin
            idx = last + k[2:0];
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end

        return pick;
    endfunction

    assign w_win       = f_rr_pick(i_req, r_last);
    assign w_can_grant = i_en & (|i_req);

    // In GRANT, r_gnt is exactly 1 << r_gnt_idx, so masking with ~r_gnt
    // leaves only the competing requesters.
    assign w_owner_req  = i_req[r_gnt_idx];
    assign w_others_req = |(i_req & ~r_gnt);
    assign w_hold_max   = (r_hold == HOLD_LAST);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_n     = r_state;
        w_gnt_n       = r_gnt;
        w_gnt_idx_n   = r_gnt_idx;
        w_gnt_valid_n = r_gnt_valid;
        w_preempt_n   = r_preempt;
        w_last_n      = r_last;
        w_hold_n      = r_hold;

        case (r_state)
            ST_IDLE: begin
                w_preempt_n = 1'b0;
                if (w_can_grant) begin
                    w_state_n     = ST_GRANT;
                    w_gnt_n       = 8'b1 << w_win;
                    w_gnt_idx_n   = w_win;
                    w_gnt_valid_n = 1'b1;
                    w_hold_n      = 8'd0;
                end
            end

            ST_GRANT: begin
                if (!w_owner_req) begin
                    // Voluntary release: the owner dropped its request.
                    w_state_n     = ST_GAP;
                    w_gnt_n       = 8'd0;
                    w_gnt_valid_n = 1'b0;
                    w_last_n      = r_gnt_idx;
                    w_preempt_n   = 1'b0;
                end else if (w_hold_max && w_others_req) begin
                    // Forced release: hold budget spent and someone is waiting.
                    w_state_n     = ST_GAP;
                    w_gnt_n       = 8'd0;
                    w_gnt_valid_n = 1'b0;
                    w_last_n      = r_gnt_idx;
                    w_preempt_n   = 1'b1;
                end else if (!w_hold_max) begin
                    w_hold_n = r_hold + 8'd1;
                end
            end

            ST_GAP: begin
                // r_last already names the outgoing owner, so the search
                // starts just past it.
                w_preempt_n = 1'b0;
                if (w_can_grant) begin
                    w_state_n     = ST_GRANT;
                    w_gnt_n       = 8'b1 << w_win;
                    w_gnt_idx_n   = w_win;
                    w_gnt_valid_n = 1'b1;
                    w_hold_n      = 8'd0;
                end else begin
                    w_state_n = ST_IDLE;
                end
            end

            default: begin
                w_state_n     = ST_IDLE;
                w_gnt_n       = 8'd0;
                w_gnt_valid_n = 1'b0;
                w_preempt_n   = 1'b0;
                w_hold_n      = 8'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    //
    // Reset sets last to 7, so the first search after reset begins at
    // requester 0.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_gnt       <= 8'd0;
            r_gnt_idx   <= 3'd0;
            r_gnt_valid <= 1'b0;
            r_preempt   <= 1'b0;
            r_last      <= 3'd7;
            r_hold      <= 8'd0;
        end else begin
            r_state     <= w_state_n;
            r_gnt       <= w_gnt_n;
            r_gnt_idx   <= w_gnt_idx_n;
            r_gnt_valid <= w_gnt_valid_n;
            r_preempt   <= w_preempt_n;
            r_last      <= w_last_n;
            r_hold      <= w_hold_n;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_gnt       = r_gnt;
    assign o_gnt_idx   = r_gnt_idx;
    assign o_gnt_valid = r_gnt_valid;
    assign o_preempt   = r_preempt;

endmodule

// File: tb/tb_rr_arbiter8.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter8
//
// Directed and randomised stimulus for rr_arbiter8 with MAX_HOLD=4.
//
// Each step does three things:
//   1. Predicts the registered outputs from a behavioural model of the
//      arbiter and pushes the prediction onto a scoreboard queue.
//   2. Clocks the design.
//   3. Pops the prediction and compares it with the design's outputs one
//      time unit after the edge.
//
// Structural invariants and the wait bound are checked on every step.
// -----------------------------------------------------------------------------
module tb_rr_arbiter8;

    localparam int MH    = 4;
    localparam int BOUND = 7 * (MH + 1);

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    rr_arbiter8 #(
        .MAX_HOLD(MH)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_req       (req),
        .o_gnt       (gnt),
        .o_gnt_idx   (gnt_idx),
        .o_gnt_valid (gnt_valid),
        .o_preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       pre;
    } exp_t;

    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;

    // -------------------------------------------------------------------------
    // Behavioural model state (0 = IDLE, 1 = GRANT, 2 = GAP)
    // -------------------------------------------------------------------------
    int         m_st    = 0;
    logic [7:0] m_gnt   = '0;
    logic [2:0] m_idx   = '0;
    logic       m_valid = 1'b0;
    logic       m_pre   = 1'b0;
    logic [2:0] m_last  = 3'd7;
    int         m_hold  = 0;

    // Per-step observation state
    logic [7:0] prev_gnt = '0;
    int         waitc[8];
    int         pre_cnt  = 0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model_pick(input logic [7:0] r,
                                              input logic [2:0] last);
        logic [2:0] j;
        for (int k = 1; k <= 8; k++) begin
            j = last + 3'(k);
            if (r[j]) return j;
        end
        return last;
    endfunction

    task automatic model_grant(input logic [2:0] w);
        m_st    = 1;
        m_idx   = w;
        m_gnt   = 8'b1 << w;
        m_valid = 1'b1;
        m_hold  = 0;
    endtask

    task automatic model_advance();
        logic [2:0] o;
        if (rst) begin
            m_st    = 0;
            m_gnt   = '0;
            m_idx   = '0;
            m_valid = 1'b0;
            m_pre   = 1'b0;
            m_last  = 3'd7;
            m_hold  = 0;
        end else begin
            case (m_st)
                0: begin
                    m_pre = 1'b0;
                    if (en && req != 8'h00) model_grant(model_pick(req, m_last));
                end
                1: begin
                    o = m_idx;
                    if (!req[o]) begin
                        m_st    = 2;
                        m_gnt   = '0;
                        m_valid = 1'b0;
                        m_last  = o;
                        m_pre   = 1'b0;
                    end else if (m_hold == MH - 1 && (req & ~(8'b1 << o)) != 8'h00) begin
                        m_st    = 2;
                        m_gnt   = '0;
                        m_valid = 1'b0;
                        m_last  = o;
                        m_pre   = 1'b1;
                    end else if (m_hold < MH - 1) begin
                        m_hold++;
                    end
                end
                default: begin
                    m_pre = 1'b0;
                    if (en && req != 8'h00) begin
                        model_grant(model_pick(req, m_last));
                    end else begin
                        m_st = 0;
                    end
                end
            endcase
        end
    endtask

    // One clock cycle: predict, clock, compare, check invariants.
    task automatic step();
        exp_t e;
        int   maxw;

        model_advance();
        e = '{gnt: m_gnt, idx: m_idx, valid: m_valid, pre: m_pre};
        sb_q.push_back(e);

        @(posedge clk);
        #1;

        e = sb_q.pop_front();
        check("gnt",       32'(gnt),       32'(e.gnt));
        check("gnt_idx",   32'(gnt_idx),   32'(e.idx));
        check("gnt_valid", 32'(gnt_valid), 32'(e.valid));
        check("preempt",   32'(preempt),   32'(e.pre));

        check("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
        check("inv_valid",   32'(gnt_valid),      32'(|gnt));
        if (gnt_valid) check("inv_idx", 32'(gnt), 32'(8'b1 << gnt_idx));
        check("inv_gap",
              32'(prev_gnt != 8'h00 && gnt != 8'h00 && prev_gnt != gnt),
              32'd0);

        // A requester's wait restarts when it drops its request, is granted,
        // or arbitration is held off by reset/en=0. The GAP cycle straight
        // after its own grant is not counted.
        maxw = 0;
        for (int i = 0; i < 8; i++) begin
            if (rst || !en || !req[i] || gnt[i]) begin
                waitc[i] = 0;
            end else if (!prev_gnt[i]) begin
                waitc[i]++;
            end
            if (waitc[i] > maxw) maxw = waitc[i];
        end
        check("starve", 32'(maxw > BOUND), 32'd0);

        if (preempt) pre_cnt++;
        prev_gnt = gnt;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) waitc[i] = 0;

        // 1. Reset held with every request high
        rst = 1'b1;
        en  = 1'b1;
        req = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_rst_gnt", 32'(gnt),     32'h00);
            check("t1_rst_idx", 32'(gnt_idx), 32'h0);
        end
        rst = 1'b0;
        step();
        check("t1_first_gnt", 32'(gnt), 32'h01);

        // 2. All requesting: full rotation, one forced gap per owner
        pre_cnt = 0;
        for (int i = 0; i < 40; i++) step();
        check("t2_preempts",  32'(pre_cnt), 32'd8);
        check("t2_wrap_gnt",  32'(gnt),     32'h01);

        // 3. Lone requester keeps the resource; a newcomer forces it off
        req = 8'h20;
        step();
        step();
        for (int i = 0; i < 40; i++) begin
            step();
            check("t3_hold_gnt", 32'(gnt),     32'h20);
            check("t3_hold_pre", 32'(preempt), 32'd0);
        end
        req = 8'h22;
        step();
        check("t3_gap_gnt", 32'(gnt),     32'h00);
        check("t3_gap_pre", 32'(preempt), 32'd1);
        step();
        check("t3_new_gnt", 32'(gnt), 32'h02);

        // 4. Voluntary release, then the search wraps past 7 to 0
        req = 8'h08;
        step();
        step();
        check("t4_gnt3", 32'(gnt), 32'h08);
        step();
        step();
        req = 8'h00;
        step();
        check("t4_gap_gnt", 32'(gnt),     32'h00);
        check("t4_gap_pre", 32'(preempt), 32'd0);
        step();
        req = 8'h09;
        step();
        check("t4_wrap_gnt", 32'(gnt), 32'h01);

        // 5. en gates new grants only
        en  = 1'b0;
        req = 8'h10;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t5_en0_gnt", 32'(gnt), 32'h00);
        end
        en = 1'b1;
        step();
        check("t5_en1_gnt", 32'(gnt), 32'h10);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_persist_gnt", 32'(gnt), 32'h10);
        end

        // 6. Reset mid-grant restores priority to requester 0
        en  = 1'b1;
        req = 8'h40;
        step();
        step();
        check("t6_gnt6", 32'(gnt), 32'h40);
        req = 8'h41;
        rst = 1'b1;
        step();
        check("t6_rst_gnt", 32'(gnt), 32'h00);
        rst = 1'b0;
        step();
        check("t6_after_rst_gnt", 32'(gnt), 32'h01);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit in case the clock or a step ever stalls
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
